ascon_perm_seq: RTL



---
 rtl/ascon_pkg.sv | 25 ++
 rtl/ascon_perm_seq_if.sv | 29 ++
 rtl/ascon_p.sv | 51 +++++
 rtl/ascon_perm_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: round limit, round-constant helper, FSM encoding
// and the 320-bit permutation state type.
package ascon_pkg;

  localparam int unsigned ASCON_MAX_ROUNDS = 12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ascon_fsm_t;

  function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

endpackage

// File: rtl/ascon_perm_seq_if.sv
// Input and output valid/ready handshakes of ascon_perm_seq.
// master = upstream/consumer side, slave = the permutation block.
interface ascon_perm_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rounds;
  logic [63:0] in_x0;
  logic [63:0] in_x1;
  logic [63:0] in_x2;
  logic [63:0] in_x3;
  logic [63:0] in_x4;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_x0;
  logic [63:0] out_x1;
  logic [63:0] out_x2;
  logic [63:0] out_x3;
  logic [63:0] out_x4;

  modport master (
    output in_valid, in_rounds, in_x0, in_x1, in_x2, in_x3, in_x4, out_ready,
    input  in_ready, out_valid, out_x0, out_x1, out_x2, out_x3, out_x4
  );

  modport slave (
    input  in_valid, in_rounds, in_x0, in_x1, in_x2, in_x3, in_x4, out_ready,
    output in_ready, out_valid, out_x0, out_x1, out_x2, out_x3, out_x4
  );
endinterface

// File: rtl/ascon_p.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit S-box
// layer and the per-word linear diffusion layer.
module ascon_p
  import ascon_pkg::*;
(
  input  logic [7:0]   rc,
  input  ascon_state_t x_in,
  output ascon_state_t x_out
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Round constant enters the low byte of x2 ahead of the S-box input mixing.
  assign a0 = x_in.x0 ^ x_in.x4;
  assign a1 = x_in.x1;
  assign a2 = x_in.x2 ^ {56'h0, rc} ^ x_in.x1;
  assign a3 = x_in.x3;
  assign a4 = x_in.x4 ^ x_in.x3;

  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  assign x_out.x0 = s0 ^ rotr(s0, 19) ^ rotr(s0, 28);
  assign x_out.x1 = s1 ^ rotr(s1, 61) ^ rotr(s1, 39);
  assign x_out.x2 = s2 ^ rotr(s2, 1)  ^ rotr(s2, 6);
  assign x_out.x3 = s3 ^ rotr(s3, 10) ^ rotr(s3, 17);
  assign x_out.x4 = s4 ^ rotr(s4, 7)  ^ rotr(s4, 41);

endmodule

// File: rtl/ascon_perm_seq.sv
// Sequential Ascon p^a/p^b driver: one round per clock around ascon_p.
// Define ASCON_UNROLL2_EN to chain two rounds per clock (same results, ~half latency).
module ascon_perm_seq
  import ascon_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
  input  logic              clk,
  input  logic              rst,
  ascon_perm_seq_if.slave   bus
);

  ascon_fsm_t   fsm;
  logic [3:0]   idx;
  ascon_state_t st;
  logic         out_valid_q;

  ascon_state_t in_st;
  ascon_state_t r1;
  ascon_state_t next_st;
  logic [3:0]   rounds_sat;
  logic [3:0]   start_idx;
  logic [3:0]   step;
  logic         last_step;

  assign in_st = '{x0: bus.in_x0, x1: bus.in_x1, x2: bus.in_x2,
                   x3: bus.in_x3, x4: bus.in_x4};

  assign rounds_sat = (bus.in_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : bus.in_rounds;
  assign start_idx  = 4'(ASCON_MAX_ROUNDS) - rounds_sat;

  ascon_p u_round0 (
    .rc    (ascon_rc(idx)),
    .x_in  (st),
    .x_out (r1)
  );

`ifdef ASCON_UNROLL2_EN
  ascon_state_t r2;
  logic         single;

  ascon_p u_round1 (
    .rc    (ascon_rc(idx + 4'd1)),
    .x_in  (r1),
    .x_out (r2)
  );

  // An odd remaining count always ends on idx 11, where only one round is left.
  assign single    = (idx == 4'd11);
  assign next_st   = single ? r1 : r2;
  assign step      = single ? 4'd1 : 4'd2;
  assign last_step = (idx >= 4'd10);
`else
  assign next_st   = r1;
  assign step      = 4'd1;
  assign last_step = (idx == 4'd11);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= ST_IDLE;
      idx         <= '0;
      st          <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm)
        ST_IDLE: begin
          if (bus.in_valid) begin
            st <= in_st;
            if (rounds_sat == 4'd0) begin
              // idx is unused for a zero-round job; keep it in range
              idx         <= '0;
              fsm         <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              idx <= start_idx;
              fsm <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          st <= next_st;
          if (last_step) begin
            idx         <= '0;
            fsm         <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + step;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            fsm         <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          fsm         <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (fsm == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x0    = st.x0;
  assign bus.out_x1    = st.x1;
  assign bus.out_x2    = st.x2;
  assign bus.out_x3    = st.x3;
  assign bus.out_x4    = st.x4;

endmodule
